// File: rtl/vscale_htif_mon_pkg.sv
// Shared constants and FSM encoding for the HTIF tohost monitor.
package vscale_htif_mon_pkg;

    localparam int HTIF_PCR_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_REQ_ENC  = 3'd1;
    localparam logic [2:0] ST_RESP_ENC = 3'd2;
    localparam logic [2:0] ST_GAP_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE_ENC,
        S_REQ  = ST_REQ_ENC,
        S_RESP = ST_RESP_ENC,
        S_GAP  = ST_GAP_ENC,
        S_DONE = ST_DONE_ENC
    } mon_state_t;

endpackage

// File: rtl/vscale_htif_tohost_monitor_if.sv
// HTIF PCR request/response channel; master is the poller, slave is the core side.
interface vscale_htif_tohost_monitor_if
    import vscale_htif_mon_pkg::*;
#(
    parameter int PCR_WIDTH  = HTIF_PCR_WIDTH,
    parameter int ADDR_WIDTH = CSR_ADDR_WIDTH
) ();

    logic                  pcr_req_valid;
    logic                  pcr_req_ready;
    logic                  pcr_req_rw;
    logic [ADDR_WIDTH-1:0] pcr_req_addr;
    logic [PCR_WIDTH-1:0]  pcr_req_data;
    logic                  pcr_resp_valid;
    logic                  pcr_resp_ready;
    logic [PCR_WIDTH-1:0]  pcr_resp_data;

    modport master (
        output pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready,
        input  pcr_req_ready, pcr_resp_valid, pcr_resp_data
    );

    modport slave (
        input  pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready,
        output pcr_req_ready, pcr_resp_valid, pcr_resp_data
    );

endinterface

// File: rtl/vscale_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// One-cycle update latency; no backpressure.
module vscale_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vscale_htif_tohost_monitor.sv
// Polls the tohost CSR over HTIF PCR and latches pass/fail/timeout; first request 1 cycle after enable.
// Request valid holds through backpressure (dropped only on timeout); single outstanding read.
module vscale_htif_tohost_monitor
    import vscale_htif_mon_pkg::*;
#(
    parameter int                    PCR_WIDTH   = HTIF_PCR_WIDTH,
    parameter int                    ADDR_WIDTH  = CSR_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = CSR_ADDR_TO_HOST,
    parameter logic [PCR_WIDTH-1:0]  PASS_VALUE  = PCR_WIDTH'(1),
    parameter int                    MAX_CYCLES  = 2000,
    parameter int                    POLL_GAP    = 4,
    parameter int                    CNT_WIDTH   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    vscale_htif_tohost_monitor_if.master pcr,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [PCR_WIDTH-1:0] fail_code,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [31:0]          poll_count
);

    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

    mon_state_t       state, state_nxt;
    logic             active, resp_fire, tmo_hit;
    logic             set_pass, set_fail, set_to;
    logic [GAP_W-1:0] gap_cnt;

    assign active    = (state == S_REQ) || (state == S_RESP) || (state == S_GAP);
    assign resp_fire = (state == S_RESP) && pcr.pcr_resp_valid;
    assign tmo_hit   = (MAX_CYCLES != 0) && active && (cycle_count == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        set_pass           = 1'b0;
        set_fail           = 1'b0;
        set_to             = 1'b0;
        pcr.pcr_req_valid  = 1'b0;
        pcr.pcr_req_rw     = 1'b0;
        pcr.pcr_req_addr   = '0;
        pcr.pcr_req_data   = '0;
        pcr.pcr_resp_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_REQ;
            end
            S_REQ: begin
                pcr.pcr_req_valid = 1'b1;
                pcr.pcr_req_addr  = TOHOST_ADDR;
                if (pcr.pcr_req_ready) state_nxt = S_RESP;
            end
            S_RESP: begin
                pcr.pcr_resp_ready = 1'b1;
                if (pcr.pcr_resp_valid) begin
                    if (pcr.pcr_resp_data == '0) begin
                        state_nxt = (POLL_GAP > 0) ? S_GAP : S_REQ;
                    end else if (pcr.pcr_resp_data == PASS_VALUE) begin
                        state_nxt = S_DONE;
                        set_pass  = 1'b1;
                    end else begin
                        state_nxt = S_DONE;
                        set_fail  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = S_REQ;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // A decoded non-zero response on the limit cycle beats the timeout.
        if (tmo_hit && !set_pass && !set_fail) begin
            state_nxt = S_DONE;
            set_to    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
        end else begin
            if (set_pass || set_fail || set_to) done <= 1'b1;
            if (set_pass) pass    <= 1'b1;
            if (set_to)   timeout <= 1'b1;
            if (set_fail) begin
                fail      <= 1'b1;
                fail_code <= pcr.pcr_resp_data >> 1;
            end
        end
    end

    vscale_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (active),
        .count (cycle_count)
    );

    vscale_sat_counter #(.WIDTH(32)) u_poll_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (resp_fire),
        .count (poll_count)
    );

    vscale_sat_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != S_GAP),
        .en    (state == S_GAP),
        .count (gap_cnt)
    );

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Directed vector bench: DUT a (MAX_CYCLES=50, POLL_GAP=4) and DUT b (no timeout, back-to-back polls).
module tb_vscale_htif_tohost_monitor;

    typedef struct {
        bit          sel;      // 0 = dut a, 1 = dut b
        int          zeros;    // zero responses before the final value
        int          stall;    // cycles req_ready is held low per request
        logic [63:0] fin;
        logic        e_pass;
        logic        e_fail;
        logic        e_to;
        logic [63:0] e_code;
        int          e_polls;
        int          e_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_a = 1'b0, enable_b = 1'b0;
    logic        req_ready = 1'b0, resp_valid = 1'b0;
    logic [63:0] resp_data = '0;
    logic        sel = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    vscale_htif_tohost_monitor_if a_if ();
    vscale_htif_tohost_monitor_if b_if ();

    assign a_if.pcr_req_ready  = req_ready;
    assign a_if.pcr_resp_valid = resp_valid;
    assign a_if.pcr_resp_data  = resp_data;
    assign b_if.pcr_req_ready  = req_ready;
    assign b_if.pcr_resp_valid = resp_valid;
    assign b_if.pcr_resp_data  = resp_data;

    logic        a_done, a_pass, a_fail, a_to, b_done, b_pass, b_fail, b_to;
    logic [63:0] a_code, a_cc, b_code, b_cc;
    logic [31:0] a_pc, b_pc;

    vscale_htif_tohost_monitor #(.MAX_CYCLES(50), .POLL_GAP(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .pcr(a_if),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_to),
        .fail_code(a_code), .cycle_count(a_cc), .poll_count(a_pc)
    );

    vscale_htif_tohost_monitor #(.MAX_CYCLES(0), .POLL_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .pcr(b_if),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_to),
        .fail_code(b_code), .cycle_count(b_cc), .poll_count(b_pc)
    );

    logic        m_valid, m_rr, m_rw, m_done, m_pass, m_fail, m_to;
    logic [11:0] m_addr;
    logic [63:0] m_wdat, m_code, m_cc;
    logic [31:0] m_pc;
    assign m_valid = sel ? b_if.pcr_req_valid  : a_if.pcr_req_valid;
    assign m_rr    = sel ? b_if.pcr_resp_ready : a_if.pcr_resp_ready;
    assign m_rw    = sel ? b_if.pcr_req_rw     : a_if.pcr_req_rw;
    assign m_addr  = sel ? b_if.pcr_req_addr   : a_if.pcr_req_addr;
    assign m_wdat  = sel ? b_if.pcr_req_data   : a_if.pcr_req_data;
    assign m_done  = sel ? b_done : a_done;
    assign m_pass  = sel ? b_pass : a_pass;
    assign m_fail  = sel ? b_fail : a_fail;
    assign m_to    = sel ? b_to   : a_to;
    assign m_code  = sel ? b_code : a_code;
    assign m_cc    = sel ? b_cc   : a_cc;
    assign m_pc    = sel ? b_pc   : a_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    polls, st, hs, last_hs, lat, viol, gviol, exp_gap, bad;
        logic  pv, pr;
        string tag;
        tag = $sformatf("v%0d", idx);
        sel = v.sel;
        apply_reset();
        polls = 0; st = 0; hs = 0; last_hs = 0; lat = -1; viol = 0; gviol = 0;
        pv = 1'b0; pr = 1'b0;
        exp_gap = (v.sel ? 2 : 6) + v.stall;
        enable_a = !v.sel;
        enable_b = v.sel;
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({tag, "_first_req"}, m_valid, 1);
                enable_a = 1'b0;
                enable_b = 1'b0;
            end
            if (m_done) begin
                lat = n;
                break;
            end
            if (m_valid && m_rr) viol++;
            if (m_valid && (m_addr != 12'h780 || m_rw || m_wdat != '0)) viol++;
            if (pv && !pr && !m_valid) viol++;
            drive_idle();
            if (m_valid) begin
                if (st >= v.stall) begin
                    req_ready = 1'b1;
                    st = 0;
                    if (hs > 0 && (n - last_hs) != exp_gap) gviol++;
                    hs++;
                    last_hs = n;
                end else begin
                    st++;
                end
            end
            if (m_rr) begin
                resp_valid = 1'b1;
                resp_data  = (polls < v.zeros) ? 64'd0 : v.fin;
                polls++;
            end
            pv = m_valid;
            pr = req_ready;
        end
        drive_idle();
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_budget done never rose within 20000 cycles", tag);
        end else begin
            chk({tag, "_pass"},    m_pass, v.e_pass);
            chk({tag, "_fail"},    m_fail, v.e_fail);
            chk({tag, "_timeout"}, m_to,   v.e_to);
            chk({tag, "_code"},    m_code, v.e_code);
            chk({tag, "_polls"},   m_pc,   v.e_polls);
            chk({tag, "_cycles"},  m_cc,   v.e_cycles);
            chk({tag, "_latency"}, lat,    v.e_cycles + 1);
            chk({tag, "_handshakes"}, hs,  v.e_polls);
            chk({tag, "_proto"},   viol,   0);
            chk({tag, "_gap"},     gviol,  0);
            // Poke every input; a finished run must not react.
            enable_a = !v.sel;
            enable_b = v.sel;
            req_ready = 1'b1;
            resp_valid = 1'b1;
            resp_data = 64'h3;
            bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (m_valid || m_rr || !m_done) bad++;
            end
            chk({tag, "_frozen_hs"}, bad,  0);
            chk({tag, "_frozen_cc"}, m_cc, v.e_cycles);
            chk({tag, "_frozen_pc"}, m_pc, v.e_polls);
            enable_a = 1'b0;
            enable_b = 1'b0;
            drive_idle();
        end
    endtask

    vec_t vecs[10];

    initial begin
        int got_rr;
        //          sel zeros stall fin                     pass fail to  code                    polls cycles
        vecs[0] = '{1'b0, 2,    0,    64'h1,                  1'b1, 1'b0, 1'b0, 64'h0,                 3,    14};
        vecs[1] = '{1'b0, 0,    0,    64'h2B,                 1'b0, 1'b1, 1'b0, 64'h15,                1,    2};
        vecs[2] = '{1'b0, 0,    10,   64'h1,                  1'b1, 1'b0, 1'b0, 64'h0,                 1,    12};
        vecs[3] = '{1'b0, 1,    2,    64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 2,   12};
        vecs[4] = '{1'b0, 1000, 0,    64'h1,                  1'b0, 1'b0, 1'b1, 64'h0,                 9,    50};
        vecs[5] = '{1'b0, 8,    0,    64'h1,                  1'b1, 1'b0, 1'b0, 64'h0,                 9,    50};
        vecs[6] = '{1'b0, 8,    0,    64'h6,                  1'b0, 1'b1, 1'b0, 64'h3,                 9,    50};
        vecs[7] = '{1'b0, 0,    1000, 64'h1,                  1'b0, 1'b0, 1'b1, 64'h0,                 0,    50};
        vecs[8] = '{1'b0, 7,    0,    64'h3,                  1'b0, 1'b1, 1'b0, 64'h1,                 8,    44};
        vecs[9] = '{1'b1, 5000, 0,    64'h1,                  1'b1, 1'b0, 1'b0, 64'h0,                 5001, 10002};

        apply_reset();
        @(negedge clk);
        chk("rst_a_flags", {a_if.pcr_req_valid, a_if.pcr_resp_ready, a_done, a_pass, a_fail, a_to}, 0);
        chk("rst_a_counts", {a_cc, a_pc}, 0);
        chk("rst_a_code", a_code, 0);
        chk("rst_b_flags", {b_if.pcr_req_valid, b_if.pcr_resp_ready, b_done, b_pass, b_fail, b_to}, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset while a response is outstanding, then a late response.
        sel = 1'b0;
        apply_reset();
        enable_a = 1'b1;
        got_rr = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            enable_a = 1'b0;
            drive_idle();
            if (a_if.pcr_resp_ready) begin
                got_rr = 1;
                break;
            end
            if (a_if.pcr_req_valid) req_ready = 1'b1;
        end
        chk("mid_reached_resp", got_rr, 1);
        chk("mid_cc_before", a_cc, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_flags", {a_if.pcr_req_valid, a_if.pcr_resp_ready, a_done, a_pass, a_fail, a_to}, 0);
        chk("mid_rst_counts", {a_cc, a_pc}, 0);
        chk("mid_rst_code", a_code, 0);
        reset = 1'b1;
        resp_valid = 1'b1;
        resp_data = 64'h1;
        repeat (4) @(negedge clk);
        chk("late_resp_flags", {a_if.pcr_resp_ready, a_done, a_pass, a_fail}, 0);
        chk("late_resp_polls", a_pc, 0);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
